or1200_immu_tlb_assoc: RTL and testbench
========================================

// Module: or1200_immu_tlb_assoc
// PURPOSE
//  Parametrised N-way set-associative instruction TLB for the IMMU.
//  Sits between the CPU fetch address path and the QMEM/IC path.
//  Translates each fetch address with a registered lookup and flags miss or execute fault.
//  Software refills entries through SPRs; the block supplies a victim-way hint, single-entry invalidate and a sequenced full flush.
// PARAMETERS
//  AW         32  virtual/physical address width
//  SETS       64  sets per way, power of 2; SET_W=log2(SETS)
//  WAYS       2   associativity, power of 2 (1..8); WAY_W=max(1,log2(WAYS))
//  PAGE_BITS  13  page offset width (8 KB pages); SET_W+WAY_W<=8 required
// PORTS
//  clk            in   1   clock
//  rst            in   1   async reset, active-low
//  ic_en          in   1   instruction cache enable
//  immu_en        in   1   translation enable; 0 = pass-through
//  supv           in   1   supervisor mode
//  icpu_cycstb_i  in   1   fetch request
//  icpu_adr_i     in   AW  fetch virtual address
//  icpu_adr_o     out  AW  translated physical address
//  icpu_rty_o     out  1   retry: miss or block busy
//  icpu_err_o     out  1   execute-permission fault
//  ci_o           out  1   cache-inhibit for this fetch
//  tlb_hit_o      out  1   lookup hit pulse
//  tlb_miss_o     out  1   lookup miss pulse
//  busy_o         out  1   flush sweep in progress
//  spr_cs         in   1   SPR select
//  spr_write      in   1   SPR write strobe (qualified by spr_cs)
//  spr_addr       in   AW  SPR address
//  spr_dat_i      in   32  SPR write data
//  spr_dat_o      out  32  SPR read data (combinational)
// BEHAVIOUR
//  Reset: all valid bits, RR pointers, outputs =0; FSM=IDLE.
//  SPR map spr_addr[10:9]: 00 match reg, 01 translate reg.
//  For both: set=spr_addr[SET_W-1:0], way=spr_addr[SET_W+WAY_W-1:SET_W].
//  Match reg: [AW-1:PAGE_BITS+SET_W] VPN tag; [0] V. Translate reg: [AW-1:PAGE_BITS] PPN; [1] CI; [6] SXE; [7] UXE; other bits read 0.
//  spr_addr[10:9]=10, [0]=0: EIR write invalidates the entry in set spr_dat_i[PAGE_BITS+SET_W-1:PAGE_BITS] whose tag matches; reads 0.
//  spr_addr[10:9]=10, [0]=1: write starts a flush. Read = {busy_o, 23'b0, victim way of set spr_dat_i index, zero-padded to 8b}.
//  Lookup: accepted at cycle N when icpu_cycstb_i & ~busy_o.
//  Index = adr[PAGE_BITS+SET_W-1:PAGE_BITS]; outputs registered, valid in N+1 only.
//  Hit = V & tag equal; several ways hit -> lowest way wins.
//  N+1 on hit: adr_o={PPN,offset}; tlb_hit_o=1; ci_o=CI|~ic_en.
//  Also on hit: icpu_err_o=1 iff (supv?~SXE:~UXE); rty_o=0.
//  N+1 on miss: tlb_miss_o=1, rty_o=1; adr_o=adr_i; RR pointer of set advances mod WAYS.
//  immu_en=0: N+1 gives adr_o=adr_i, hit=1, err=0, ci_o=~ic_en; no RR update.
//  Victim: lowest invalid way of set, else RR pointer.
//  FSM IDLE->FLUSH on flush write; clears set k in cycle k (k=0..SETS-1).
//  FLUSH->IDLE after set SETS-1; busy_o=1 for exactly SETS cycles.
//  While busy: cycstb -> rty_o=1 combinationally, no lookup.
//  Flush write while busy is ignored; match/translate writes while busy still apply.
//  Same-cycle SPR write + lookup to same entry: lookup uses old contents.
//  Reset mid-flush: all valid cleared at once, FSM IDLE.
// TESTING
//  Write match(set5,way1,VPN=0x12345,V=1)/translate(PPN=0x00ABC,SXE=1); fetch VA in set5 supv=1 -> N+1 hit, adr_o={0xABC,off}, err=0.
//  Same fetch with supv=0, UXE=0 -> N+1 hit and icpu_err_o=1.
//  Fetch unmapped VA -> tlb_miss_o=1 and rty_o=1 at N+1, then flush-reg read of that set shows the RR victim pointer advanced.
//  Set both ways of set 5 valid, invalidate way0 via EIR -> victim read=0; re-fetch of way0 VA misses.
//  Flush write -> busy_o high exactly SETS cycles, fetches get rty_o; afterwards every prior hit misses.
//  immu_en=0, ic_en=0, adr=0xDEAD0000 -> N+1 adr_o=0xDEAD0000, ci_o=1; rst low mid-flush -> busy_o=0 at once.

Source files
------------

// File: rtl/or1200_immu_tlb_assoc.sv
// or1200_immu_tlb_assoc
//   N-way set-associative instruction TLB. Each accepted fetch is looked up
//   in one cycle, and the result appears on registered outputs in the
//   following cycle. Software refills entries through SPRs. The block also
//   provides a victim-way hint, a single-entry invalidate (EIR) and a
//   sequenced full flush that clears one set per cycle.
// Ports
//   clk, rst (async, active-low)
//   ic_en, immu_en, supv               : mode inputs
//   icpu_cycstb_i / icpu_adr_i         : fetch request and virtual address
//   icpu_adr_o, icpu_rty_o, icpu_err_o : translated address, retry, exec fault
//   ci_o, tlb_hit_o, tlb_miss_o        : cache inhibit, lookup result pulses
//   busy_o                             : flush sweep in progress
//   spr_cs/spr_write/spr_addr/spr_dat_i/spr_dat_o : SPR access
module or1200_immu_tlb_assoc #(
  parameter int AW        = 32,
  parameter int SETS      = 64,
  parameter int WAYS      = 2,
  parameter int PAGE_BITS = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_en,
  input  logic          immu_en,
  input  logic          supv,
  input  logic          icpu_cycstb_i,
  input  logic [AW-1:0] icpu_adr_i,
  output logic [AW-1:0] icpu_adr_o,
  output logic          icpu_rty_o,
  output logic          icpu_err_o,
  output logic          ci_o,
  output logic          tlb_hit_o,
  output logic          tlb_miss_o,
  output logic          busy_o,
  input  logic          spr_cs,
  input  logic          spr_write,
  input  logic [AW-1:0] spr_addr,
  input  logic [31:0]   spr_dat_i,
  output logic [31:0]   spr_dat_o
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = AW - PAGE_BITS - SET_W;
  localparam int PPN_W = AW - PAGE_BITS;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  // Valid bits and round-robin pointers are reset. The payload is not reset,
  // because it is only used when the valid bit is set.
  logic [WAYS-1:0][SETS-1:0]  vld;
  logic [SETS-1:0][WAY_W-1:0] rr;
  logic [TAG_W-1:0] tag_mem [WAYS][SETS];
  logic [PPN_W-1:0] ppn_mem [WAYS][SETS];
  logic             ci_mem  [WAYS][SETS];
  logic             sxe_mem [WAYS][SETS];
  logic             uxe_mem [WAYS][SETS];

  state_t           state;
  logic [SET_W-1:0] fl_set;

  logic [AW-1:0] adr_q;
  logic          hit_q, miss_q, err_q, ci_q, rty_q;

  // SPR decode
  logic             spr_we, match_wr, xlat_wr, eir_wr, flush_wr;
  logic [SET_W-1:0] spr_set, eir_set;
  logic [WAY_W-1:0] spr_way;
  logic [TAG_W-1:0] eir_tag;

  assign spr_we   = spr_cs & spr_write;
  assign match_wr = spr_we & (spr_addr[10:9] == 2'b00);
  assign xlat_wr  = spr_we & (spr_addr[10:9] == 2'b01);
  assign eir_wr   = spr_we & (spr_addr[10:9] == 2'b10) & ~spr_addr[0];
  assign flush_wr = spr_we & (spr_addr[10:9] == 2'b10) &  spr_addr[0];
  assign spr_set  = spr_addr[SET_W-1:0];
  assign spr_way  = spr_addr[SET_W+WAY_W-1:SET_W];
  assign eir_set  = spr_dat_i[PAGE_BITS+SET_W-1:PAGE_BITS];
  assign eir_tag  = spr_dat_i[AW-1:PAGE_BITS+SET_W];

  assign busy_o = (state == S_FLUSH);

  // Lookup. The loop runs from the highest way down, so the lowest hitting
  // way is the one that wins.
  logic [SET_W-1:0] l_set;
  logic [TAG_W-1:0] l_tag;
  logic             accept, hit_any, hit_ci, hit_sxe, hit_uxe;
  logic [PPN_W-1:0] hit_ppn;

  assign l_set  = icpu_adr_i[PAGE_BITS+SET_W-1:PAGE_BITS];
  assign l_tag  = icpu_adr_i[AW-1:PAGE_BITS+SET_W];
  assign accept = icpu_cycstb_i & ~busy_o;

  always_comb begin
    hit_any = 1'b0;
    hit_ppn = '0;
    hit_ci  = 1'b0;
    hit_sxe = 1'b0;
    hit_uxe = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (vld[w][l_set] && tag_mem[w][l_set] == l_tag) begin
        hit_any = 1'b1;
        hit_ppn = ppn_mem[w][l_set];
        hit_ci  = ci_mem[w][l_set];
        hit_sxe = sxe_mem[w][l_set];
        hit_uxe = uxe_mem[w][l_set];
      end
    end
  end

  // Victim hint for the set named by spr_dat_i: the lowest invalid way if
  // there is one, otherwise the round-robin pointer.
  logic [WAY_W-1:0] victim;
  always_comb begin
    victim = rr[eir_set];
    for (int w = WAYS-1; w >= 0; w--)
      if (!vld[w][eir_set]) victim = WAY_W'(w);
  end

  // SPR read mux
  always_comb begin
    spr_dat_o = '0;
    case (spr_addr[10:9])
      2'b00: for (int w = 0; w < WAYS; w++)
        if (WAY_W'(w) == spr_way) begin
          spr_dat_o[AW-1:PAGE_BITS+SET_W] = tag_mem[w][spr_set];
          spr_dat_o[0]                    = vld[w][spr_set];
        end
      2'b01: for (int w = 0; w < WAYS; w++)
        if (WAY_W'(w) == spr_way) begin
          spr_dat_o[AW-1:PAGE_BITS] = ppn_mem[w][spr_set];
          spr_dat_o[7]              = uxe_mem[w][spr_set];
          spr_dat_o[6]              = sxe_mem[w][spr_set];
          spr_dat_o[1]              = ci_mem[w][spr_set];
        end
      2'b10: if (spr_addr[0]) spr_dat_o = {busy_o, 23'b0, 8'(victim)};
      default: spr_dat_o = '0;
    endcase
  end

  // Entry payload storage
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (match_wr && WAY_W'(w) == spr_way)
        tag_mem[w][spr_set] <= spr_dat_i[AW-1:PAGE_BITS+SET_W];
      if (xlat_wr && WAY_W'(w) == spr_way) begin
        ppn_mem[w][spr_set] <= spr_dat_i[AW-1:PAGE_BITS];
        ci_mem[w][spr_set]  <= spr_dat_i[1];
        sxe_mem[w][spr_set] <= spr_dat_i[6];
        uxe_mem[w][spr_set] <= spr_dat_i[7];
      end
    end
  end

  // Valid bits, flush FSM, round-robin pointers and registered lookup result.
  // The lookup reads the pre-edge arrays, so a same-cycle SPR write is not
  // visible to it. A flush write arriving while the FSM is in FLUSH is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= '0;
      rr     <= '0;
      state  <= S_IDLE;
      fl_set <= '0;
      adr_q  <= '0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      err_q  <= 1'b0;
      ci_q   <= 1'b0;
      rty_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (flush_wr) begin
          state  <= S_FLUSH;
          fl_set <= '0;
        end
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) vld[w][fl_set] <= 1'b0;
          fl_set <= fl_set + SET_W'(1);
          if (fl_set == SET_W'(SETS-1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      for (int w = 0; w < WAYS; w++) begin
        if (eir_wr && vld[w][eir_set] && tag_mem[w][eir_set] == eir_tag)
          vld[w][eir_set] <= 1'b0;
        if (match_wr && WAY_W'(w) == spr_way)
          vld[w][spr_set] <= spr_dat_i[0];
      end

      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      err_q  <= 1'b0;
      ci_q   <= 1'b0;
      rty_q  <= 1'b0;
      if (accept) begin
        if (!immu_en) begin
          adr_q <= icpu_adr_i;
          hit_q <= 1'b1;
          ci_q  <= ~ic_en;
        end else if (hit_any) begin
          adr_q <= {hit_ppn, icpu_adr_i[PAGE_BITS-1:0]};
          hit_q <= 1'b1;
          ci_q  <= hit_ci | ~ic_en;
          err_q <= supv ? ~hit_sxe : ~hit_uxe;
        end else begin
          adr_q  <= icpu_adr_i;
          miss_q <= 1'b1;
          rty_q  <= 1'b1;
          rr[l_set] <= (rr[l_set] == WAY_W'(WAYS-1)) ? '0 : rr[l_set] + WAY_W'(1);
        end
      end
    end
  end

  assign icpu_adr_o = adr_q;
  assign tlb_hit_o  = hit_q;
  assign tlb_miss_o = miss_q;
  assign icpu_err_o = err_q;
  assign ci_o       = ci_q;
  assign icpu_rty_o = rty_q | (icpu_cycstb_i & busy_o);

endmodule

// File: tb/tb_or1200_immu_tlb_assoc.sv
// Directed bench for or1200_immu_tlb_assoc (default parameters: 64 sets, 2 ways).
// Inputs are driven on the falling edge, and the registered outputs are
// sampled on the following falling edge.
module tb_or1200_immu_tlb_assoc;
  logic        clk = 1'b0;
  logic        rst;
  logic        ic_en, immu_en, supv, icpu_cycstb_i;
  logic [31:0] icpu_adr_i, icpu_adr_o;
  logic        icpu_rty_o, icpu_err_o, ci_o, tlb_hit_o, tlb_miss_o, busy_o;
  logic        spr_cs, spr_write;
  logic [31:0] spr_addr, spr_dat_i, spr_dat_o;

  int checks = 0;
  int fails  = 0;
  int n;
  logic [31:0] rd;

  or1200_immu_tlb_assoc dut (
    .clk(clk), .rst(rst), .ic_en(ic_en), .immu_en(immu_en), .supv(supv),
    .icpu_cycstb_i(icpu_cycstb_i), .icpu_adr_i(icpu_adr_i),
    .icpu_adr_o(icpu_adr_o), .icpu_rty_o(icpu_rty_o), .icpu_err_o(icpu_err_o),
    .ci_o(ci_o), .tlb_hit_o(tlb_hit_o), .tlb_miss_o(tlb_miss_o),
    .busy_o(busy_o), .spr_cs(spr_cs), .spr_write(spr_write),
    .spr_addr(spr_addr), .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spr_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_dat_i = d;
    @(negedge clk);
    spr_cs = 1'b0; spr_write = 1'b0;
  endtask

  task automatic spr_rd(input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    spr_cs = 1'b1; spr_write = 1'b0; spr_addr = a; spr_dat_i = d;
    #1 r = spr_dat_o;
    spr_cs = 1'b0;
  endtask

  // The task returns on the falling edge at which the N+1 outputs can be read.
  task automatic fetch(input logic [31:0] va);
    @(negedge clk);
    icpu_cycstb_i = 1'b1; icpu_adr_i = va;
    @(negedge clk);
    icpu_cycstb_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ic_en = 1'b1; immu_en = 1'b1; supv = 1'b1;
    icpu_cycstb_i = 1'b0; icpu_adr_i = '0;
    spr_cs = 1'b0; spr_write = 1'b0; spr_addr = '0; spr_dat_i = '0;
    #1;
    chk("rst_adr",  icpu_adr_o, 32'h0);
    chk("rst_hit",  {31'b0, tlb_hit_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_rty",  {31'b0, icpu_rty_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // set 5, way 1: VPN 0x12345 -> PPN 0xABC, SXE only
    spr_wr(32'h045, 32'h2468A001);
    spr_wr(32'h245, 32'h01578040);
    // set 5, way 0: VPN 0x00045 -> PPN 0x111, UXE|SXE|CI
    spr_wr(32'h005, 32'h00080001);
    spr_wr(32'h205, 32'h002220C2);

    spr_rd(32'h045, 32'h0, rd);  chk("rd_match", rd, 32'h24680001);
    spr_rd(32'h245, 32'h0, rd);  chk("rd_xlat",  rd, 32'h01578040);

    supv = 1'b1;
    fetch(32'h2468A123);
    chk("hit_adr",  icpu_adr_o, 32'h01578123);
    chk("hit_hit",  {31'b0, tlb_hit_o}, 32'h1);
    chk("hit_err",  {31'b0, icpu_err_o}, 32'h0);
    chk("hit_rty",  {31'b0, icpu_rty_o}, 32'h0);
    chk("hit_ci",   {31'b0, ci_o}, 32'h0);

    supv = 1'b0;
    fetch(32'h2468A123);
    chk("user_hit", {31'b0, tlb_hit_o}, 32'h1);
    chk("user_err", {31'b0, icpu_err_o}, 32'h1);

    fetch(32'h0008A456);
    chk("w0_adr", icpu_adr_o, 32'h00222456);
    chk("w0_ci",  {31'b0, ci_o}, 32'h1);
    chk("w0_err", {31'b0, icpu_err_o}, 32'h0);

    // round-robin victim moves on a miss once both ways are valid
    spr_rd(32'h401, 32'h0000A000, rd);  chk("vic_before", rd, 32'h0);
    fetch(32'h0000A010);
    chk("miss_miss", {31'b0, tlb_miss_o}, 32'h1);
    chk("miss_rty",  {31'b0, icpu_rty_o}, 32'h1);
    chk("miss_hit",  {31'b0, tlb_hit_o}, 32'h0);
    chk("miss_adr",  icpu_adr_o, 32'h0000A010);
    spr_rd(32'h401, 32'h0000A000, rd);  chk("vic_after", rd, 32'h1);

    // EIR invalidate of way 0
    spr_wr(32'h400, 32'h0008A000);
    spr_rd(32'h401, 32'h0000A000, rd);  chk("vic_eir", rd, 32'h0);
    fetch(32'h0008A000);
    chk("eir_miss", {31'b0, tlb_miss_o}, 32'h1);
    fetch(32'h2468A000);
    chk("eir_w1_hit", {31'b0, tlb_hit_o}, 32'h1);
    chk("eir_w1_adr", icpu_adr_o, 32'h01578000);

    // flush sweep. A second flush write partway through must not extend it.
    @(negedge clk);
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 32'h401; spr_dat_i = 32'h0;
    @(negedge clk);
    spr_cs = 1'b0; spr_write = 1'b0;
    chk("fl_busy", {31'b0, busy_o}, 32'h1);
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin
      n++;
      if (n == 1) begin
        icpu_cycstb_i = 1'b1; icpu_adr_i = 32'h2468A000;
        spr_cs = 1'b1; spr_addr = 32'h401; spr_dat_i = 32'h0;
        #1;
        chk("fl_rty", {31'b0, icpu_rty_o}, 32'h1);
        chk("fl_rd_busy", spr_dat_o, 32'h80000000);
        spr_cs = 1'b0;
      end
      if (n == 2) begin
        chk("fl_nolookup", {30'b0, tlb_hit_o, tlb_miss_o}, 32'h0);
        icpu_cycstb_i = 1'b0;
      end
      if (n == 10) begin
        spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 32'h401;
      end
      if (n == 11) begin
        spr_cs = 1'b0; spr_write = 1'b0;
      end
      @(negedge clk);
    end
    chk("fl_len", n, 32'd64);

    fetch(32'h2468A123);
    chk("post_fl_miss", {31'b0, tlb_miss_o}, 32'h1);

    // a match write and a lookup in the same cycle: the lookup sees the old entry
    @(negedge clk);
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 32'h045; spr_dat_i = 32'h2468A001;
    icpu_cycstb_i = 1'b1; icpu_adr_i = 32'h2468A123;
    @(negedge clk);
    spr_cs = 1'b0; spr_write = 1'b0; icpu_cycstb_i = 1'b0;
    chk("same_cyc_miss", {31'b0, tlb_miss_o}, 32'h1);
    fetch(32'h2468A123);
    chk("refill_hit", {31'b0, tlb_hit_o}, 32'h1);
    chk("refill_adr", icpu_adr_o, 32'h01578123);

    // pass-through mode
    immu_en = 1'b0; ic_en = 1'b0;
    fetch(32'hDEAD0000);
    chk("pt_adr", icpu_adr_o, 32'hDEAD0000);
    chk("pt_ci",  {31'b0, ci_o}, 32'h1);
    chk("pt_hit", {31'b0, tlb_hit_o}, 32'h1);
    chk("pt_err", {31'b0, icpu_err_o}, 32'h0);
    immu_en = 1'b1; ic_en = 1'b1;

    // reset in the middle of a flush
    spr_wr(32'h401, 32'h0);
    chk("mid_busy", {31'b0, busy_o}, 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    fetch(32'h2468A123);
    chk("mid_rst_miss", {31'b0, tlb_miss_o}, 32'h1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
